// File: rtl/division_seq.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, valid/ready on both sides.
// Optional two's-complement mode when DIVISION_SEQ_SIGNED_EN is defined (adds the Sgn port).
module division_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Res,
  output logic [WIDTH-1:0] Rem,
  output logic             div_zero,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DIVISION_SEQ_SIGNED_EN
  ,
  input  logic             Sgn
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;     // original dividend, returned as Rem on divide-by-zero
  logic [WIDTH-1:0] dvd_q;   // dividend shifts out MSB-first while quotient shifts in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] prem_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] rem_q;
  logic             dz_q;
  logic             zero_q;
  logic             ov_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic [WIDTH:0]   prem_sh;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] prem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg_quo_d;
  logic             neg_rem_d;

  // One restoring step: the trial subtraction is done as a (WIDTH+1)-bit compare,
  // and only the low WIDTH bits of the difference can survive since prem < divisor.
  always_comb begin
    prem_sh = {prem_q, dvd_q[WIDTH-1]};
    ge      = (prem_sh >= {1'b0, dvs_q});
    diff    = prem_sh[WIDTH-1:0] - dvs_q;
    prem_d  = ge ? diff : prem_sh[WIDTH-1:0];
    quo_d   = {dvd_q[WIDTH-2:0], ge};
    res_d   = neg_quo_q ? -quo_d  : quo_d;
    rem_d   = neg_rem_q ? -prem_d : prem_d;
  end

`ifdef DIVISION_SEQ_SIGNED_EN
  // MIN negates to itself, which is the correct unsigned magnitude 2**(WIDTH-1).
  always_comb begin
    neg_quo_d = Sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
    neg_rem_d = Sgn & A[WIDTH-1];
    a_mag     = (Sgn & A[WIDTH-1]) ? -A : A;
    b_mag     = (Sgn & B[WIDTH-1]) ? -B : B;
  end
`else
  always_comb begin
    neg_quo_d = 1'b0;
    neg_rem_d = 1'b0;
    a_mag     = A;
    b_mag     = B;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      prem_q    <= '0;
      res_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
      zero_q    <= 1'b0;
      ov_q      <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q       <= A;
            dvd_q     <= a_mag;
            dvs_q     <= b_mag;
            prem_q    <= '0;
            cnt_q     <= '0;
            zero_q    <= (B == '0);
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            state_q   <= CALC;
          end
        end
        CALC: begin
          // A zero divisor spends a single cycle here, so its result is ready one edge after accept.
          if (zero_q) begin
            res_q   <= '1;
            rem_q   <= a_q;
            dz_q    <= 1'b1;
            ov_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            prem_q <= prem_d;
            dvd_q  <= quo_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              res_q   <= res_d;
              rem_q   <= rem_d;
              dz_q    <= 1'b0;
              ov_q    <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign Res       = res_q;
  assign Rem       = rem_q;
  assign div_zero  = dz_q;
  assign out_valid = ov_q;

endmodule
